// File: rtl/fc3_bias_fetch_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fc3_bias_pkg
//  Description : Shared constants for the FC3 bias fetch/add block. Holds the
//                default geometry, the FSM state encoding and the output
//                saturation limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package fc3_bias_pkg;

    // Default geometry
    localparam int FC3_LANES     = 16;
    localparam int FC3_NUM_BATCH = 2;
    localparam int FC3_AW        = 1;
    localparam int FC3_BIAS_W    = 34;
    localparam int FC3_ACC_W     = 34;
    localparam int FC3_OUT_W     = 8;
    localparam int FC3_SHIFT     = 16;

    // Saturation and rounding limits for the default geometry
    localparam int FC3_OUT_MAX   = (1 << (FC3_OUT_W - 1)) - 1;
    localparam int FC3_OUT_MIN   = -(1 << (FC3_OUT_W - 1));
    localparam int FC3_RND_HALF  = (FC3_SHIFT > 0) ? (1 << (FC3_SHIFT - 1)) : 0;

    // Sequencer states
    typedef enum logic [2:0] {
        FC3_IDLE  = 3'd0,
        FC3_FETCH = 3'd1,
        FC3_WAIT  = 3'd2,
        FC3_ACC   = 3'd3,
        FC3_OUT   = 3'd4
    } fc3_state_e;

    // Fixed-width encodings used by the sequencer register
    localparam logic [2:0] S_IDLE  = FC3_IDLE;
    localparam logic [2:0] S_FETCH = FC3_FETCH;
    localparam logic [2:0] S_WAIT  = FC3_WAIT;
    localparam logic [2:0] S_ACC   = FC3_ACC;
    localparam logic [2:0] S_OUT   = FC3_OUT;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc3_bias_fetch_add_if.sv
`default_nettype none
// ============================================================================
//  Module      : fc3_bias_fetch_add_if
//  Description : Bus bundle for the FC3 bias fetch/add block: bias ROM read
//                port, accumulator input stream and result output stream.
//  Ports       : master - the fetch/add block (drives ROM request, acc_ready,
//                         out_valid/out_data)
//                slave  - surrounding logic (ROM, MAC array, writeback)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fc3_bias_fetch_add_if
    import fc3_bias_pkg::*;
#(
    parameter int LANES  = FC3_LANES,
    parameter int AW     = FC3_AW,
    parameter int BIAS_W = FC3_BIAS_W,
    parameter int ACC_W  = FC3_ACC_W,
    parameter int OUT_W  = FC3_OUT_W
);
    logic [AW-1:0]           rom_aa;
    logic                    rom_cena;
    logic [LANES*BIAS_W-1:0] rom_qa;
    logic                    acc_valid;
    logic                    acc_ready;
    logic [LANES*ACC_W-1:0]  acc_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*OUT_W-1:0]  out_data;

    modport master (
        output rom_aa, rom_cena, acc_ready, out_valid, out_data,
        input  rom_qa, acc_valid, acc_data, out_ready
    );

    modport slave (
        input  rom_aa, rom_cena, acc_ready, out_valid, out_data,
        output rom_qa, acc_valid, acc_data, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fc3_bias_fetch_add_requant_lane.sv
`default_nettype none
// ============================================================================
//  Module      : fc3_requant_lane
//  Description : Combinational per-lane requantizer: acc + bias, round half
//                up, arithmetic right shift by SHIFT, saturate to OUT_W.
//  Ports       : acc    in  ACC_W   signed partial sum
//                bias   in  BIAS_W  signed bias
//                result out OUT_W   signed saturated output
//  Revision    : 1.0 - initial release
// ============================================================================
module fc3_requant_lane
    import fc3_bias_pkg::*;
#(
    parameter int ACC_W  = FC3_ACC_W,
    parameter int BIAS_W = FC3_BIAS_W,
    parameter int OUT_W  = FC3_OUT_W,
    parameter int SHIFT  = FC3_SHIFT
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [BIAS_W-1:0] bias,
    output logic [OUT_W-1:0]  result
);
    // One bit beyond the exact sum width so the rounding increment can
    // never wrap even when both operands sit at their positive limit.
    localparam int SUM_W = max_int(ACC_W, BIAS_W) + 2;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        $signed({{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_rnd;
    logic signed [SUM_W-1:0] w_shr;

    assign w_sum = $signed({{(SUM_W - ACC_W){acc[ACC_W-1]}}, acc})
                 + $signed({{(SUM_W - BIAS_W){bias[BIAS_W-1]}}, bias});

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [SUM_W-1:0] HALF = SUM_W'(64'd1 << (SHIFT - 1));
            assign w_rnd = w_sum + HALF;
        end else begin : g_no_round
            assign w_rnd = w_sum;
        end
    endgenerate

    assign w_shr = w_rnd >>> SHIFT;

    always_comb begin
        result = w_shr[OUT_W-1:0];
        if (w_shr > SAT_MAX) begin
            result = SAT_MAX[OUT_W-1:0];
        end else if (w_shr < SAT_MIN) begin
            result = SAT_MIN[OUT_W-1:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/fc3_bias_fetch_add.sv
`default_nettype none
// ============================================================================
//  Module      : fc3_bias_fetch_add
//  Description : FC3 bias read sequencer. Per output batch it reads one ROM
//                row (active-low enable, data one cycle later), adds the
//                lane biases to the matching accumulator beat, requantizes
//                and presents the result downstream under valid/ready.
//  Ports       : clk, rst  clock and synchronous active-high reset
//                start     one-cycle pulse starting an inference pass
//                busy      high from accepted start until done
//                done      one-cycle pulse after the last batch is accepted
//                bus       ROM port, accumulator stream, result stream
//  Revision    : 1.0 - initial release
// ============================================================================
module fc3_bias_fetch_add
    import fc3_bias_pkg::*;
#(
    parameter int LANES     = FC3_LANES,
    parameter int NUM_BATCH = FC3_NUM_BATCH,
    parameter int AW        = FC3_AW,
    parameter int BIAS_W    = FC3_BIAS_W,
    parameter int ACC_W     = FC3_ACC_W,
    parameter int OUT_W     = FC3_OUT_W,
    parameter int SHIFT     = FC3_SHIFT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    fc3_bias_fetch_add_if.master bus
);
    localparam logic [AW-1:0] LAST_BATCH = AW'(NUM_BATCH - 1);

    logic [2:0]              r_state;
    logic [AW-1:0]           r_batch;
    logic [LANES*BIAS_W-1:0] r_bias;
    logic [LANES*OUT_W-1:0]  r_out_data;
    logic                    r_out_valid;
    logic                    r_busy;
    logic                    r_done;
    logic [LANES*OUT_W-1:0]  w_req;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            fc3_requant_lane #(
                .ACC_W  (ACC_W),
                .BIAS_W (BIAS_W),
                .OUT_W  (OUT_W),
                .SHIFT  (SHIFT)
            ) u_lane (
                .acc    (bus.acc_data[i*ACC_W +: ACC_W]),
                .bias   (r_bias[i*BIAS_W +: BIAS_W]),
                .result (w_req[i*OUT_W +: OUT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_batch     <= '0;
            r_bias      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_batch <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // ROM data is valid exactly one cycle after the read.
                    r_bias  <= bus.rom_qa;
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    if (bus.acc_valid) begin
                        r_out_data  <= w_req;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_batch == LAST_BATCH) begin
                            r_batch <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_batch <= r_batch + AW'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_cena  = (r_state != S_FETCH);
    assign bus.rom_aa    = r_batch;
    assign bus.acc_ready = (r_state == S_ACC);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign busy          = r_busy;
    assign done          = r_done;
endmodule
`default_nettype wire

// File: tb/tb_fc3_bias_fetch_add.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc3_bias_fetch_add
//  Description : Self-checking bench for fc3_bias_fetch_add. A ROM model
//                answers reads, a scoreboard predicts every result from the
//                arithmetic definition, and directed tests pin timing,
//                rounding, saturation, backpressure and reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc3_bias_fetch_add;
    localparam int LANES  = 16;
    localparam int NB     = 2;
    localparam int ADDR_W = 1;
    localparam int BIAS_W = 34;
    localparam int ACC_W  = 34;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 16;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    int errors = 0;
    int checks = 0;

    fc3_bias_fetch_add_if #(
        .LANES(LANES), .AW(ADDR_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) bus ();

    fc3_bias_fetch_add #(
        .LANES(LANES), .NUM_BATCH(NB), .AW(ADDR_W), .BIAS_W(BIAS_W),
        .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // ---------------- ROM model ----------------
    logic [LANES*BIAS_W-1:0] rom_mem [NB];

    function automatic logic [LANES*BIAS_W-1:0] junk();
        logic [LANES*BIAS_W-1:0] j;
        for (int i = 0; i < LANES*BIAS_W; i += 32) j[i +: 32] = $urandom;
        return j;
    endfunction

    // Data appears only the cycle after a sampled read; otherwise garbage.
    always @(posedge clk) begin
        if (!bus.rom_cena) bus.rom_qa <= rom_mem[bus.rom_aa];
        else               bus.rom_qa <= junk();
    end

    // ---------------- arithmetic model ----------------
    function automatic logic [LANES*OUT_W-1:0] model_row(
        input logic [LANES*ACC_W-1:0]  acc,
        input logic [LANES*BIAS_W-1:0] bias
    );
        logic [LANES*OUT_W-1:0] o;
        longint a, b, s;
        for (int k = 0; k < LANES; k++) begin
            a = longint'($signed(acc[k*ACC_W +: ACC_W]));
            b = longint'($signed(bias[k*BIAS_W +: BIAS_W]));
            s = a + b;
            if (SHIFT > 0) s = s + (longint'(1) << (SHIFT - 1));
            s = s >>> SHIFT;
            if (s > longint'(2**(OUT_W-1) - 1)) s = longint'(2**(OUT_W-1) - 1);
            if (s < -longint'(2**(OUT_W-1)))    s = -longint'(2**(OUT_W-1));
            o[k*OUT_W +: OUT_W] = s[OUT_W-1:0];
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int           model_batch = 0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_batch <= 0;
        end else begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (bus.acc_valid && bus.acc_ready) begin
                exp_q.push_back(model_row(bus.acc_data, rom_mem[model_batch]));
                model_batch <= (model_batch + 1) % NB;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            chk("sb_has_entry", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) chk("out_data_model", bus.out_data, exp_q[0]);
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},      busy,          0);
        chk({tag, "_done"},      done,          0);
        chk({tag, "_rom_cena"},  bus.rom_cena,  1);
        chk({tag, "_rom_aa"},    bus.rom_aa,    0);
        chk({tag, "_acc_ready"}, bus.acc_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"},  bus.out_data,  0);
    endtask

    task automatic wait_acc_ready(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.acc_ready) break;
            step();
        end
        chk({tag, "_acc_ready_timeout"}, bus.acc_ready, 1);
    endtask

    // One batch: offer beat, optionally stall downstream, then accept.
    task automatic do_beat(input string tag, input logic [LANES*ACC_W-1:0] acc,
                           input logic [127:0] lit, input logic [127:0] mask,
                           input int stall, input bit last);
        logic [127:0] held;
        bus.acc_data = acc;
        wait_acc_ready(tag);
        bus.acc_valid = 1'b1;
        step();
        bus.acc_valid = 1'b0;
        chk({tag, "_out_valid"}, bus.out_valid, 1);
        if (mask != 0) chk({tag, "_literal"}, bus.out_data & mask, lit & mask);
        held = bus.out_data;
        for (int s = 0; s < stall; s++) begin
            if (s == 1) start = 1'b1;
            if (s == 2) bus.acc_valid = 1'b1;
            step();
            start = 1'b0;
            bus.acc_valid = 1'b0;
            chk({tag, "_stall_data"},      bus.out_data,  held);
            chk({tag, "_stall_acc_ready"}, bus.acc_ready, 0);
            chk({tag, "_stall_rom_cena"},  bus.rom_cena,  1);
            chk({tag, "_stall_valid"},     bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_done"}, done, last ? 1 : 0);
        chk({tag, "_busy"}, busy, last ? 0 : 1);
    endtask

    // ---------------- stimulus ----------------
    logic [LANES*ACC_W-1:0] acc_a, acc_b;
    logic [127:0]           lit_k, lit_3k2, lit_a, mask_a;

    initial begin
        bus.acc_valid = 1'b0;
        bus.acc_data  = '0;
        bus.out_ready = 1'b0;

        // Row 0: saturation and rounding biases. Row 1: distinct per lane.
        rom_mem[0] = '0;
        rom_mem[0][0*BIAS_W +: BIAS_W] = 34'(750085376);
        rom_mem[0][1*BIAS_W +: BIAS_W] = 34'(-103524808);
        rom_mem[0][2*BIAS_W +: BIAS_W] = 34'(32768);
        rom_mem[1] = '0;
        for (int k = 0; k < LANES; k++) rom_mem[1][k*BIAS_W +: BIAS_W] = 34'((k + 1) * 131072);

        acc_a = '0;
        acc_a[2*ACC_W +: ACC_W] = 34'(196608);
        acc_a[3*ACC_W +: ACC_W] = 34'(-229376);
        acc_a[4*ACC_W +: ACC_W] = 34'(65535);
        for (int k = 5; k < LANES; k++) acc_a[k*ACC_W +: ACC_W] = 34'(k * 123457 - 900000);
        acc_b = '0;
        for (int k = 0; k < LANES; k++) acc_b[k*ACC_W +: ACC_W] = 34'(k * 65536);

        lit_a   = {88'd0, 8'h01, 8'hFD, 8'h04, 8'h80, 8'h7F};
        mask_a  = {88'd0, 40'hFF_FFFF_FFFF};
        lit_k   = '0;
        lit_3k2 = '0;
        for (int k = 0; k < LANES; k++) begin
            lit_k[k*8 +: 8]   = 8'(k);
            lit_3k2[k*8 +: 8] = 8'(3 * k + 2);
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        // Handshake timing: start in cycle 0, acc_valid and out_ready held
        start = 1'b1;
        bus.acc_valid = 1'b1;
        bus.acc_data  = acc_a;
        bus.out_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            start = 1'b0;
            chk($sformatf("t%0d_rom_cena", c),  bus.rom_cena,  (c == 1 || c == 5) ? 0 : 1);
            chk($sformatf("t%0d_acc_ready", c), bus.acc_ready, (c == 3 || c == 7) ? 1 : 0);
            chk($sformatf("t%0d_out_valid", c), bus.out_valid, (c == 4 || c == 8) ? 1 : 0);
            chk($sformatf("t%0d_done", c),      done,          (c == 9) ? 1 : 0);
            chk($sformatf("t%0d_busy", c),      busy,          (c >= 1 && c <= 8) ? 1 : 0);
            if (c == 1) chk("t1_rom_aa", bus.rom_aa, 0);
            if (c == 5) chk("t5_rom_aa", bus.rom_aa, 1);
            if (c == 4) chk("t4_sat_round", bus.out_data & mask_a, lit_a);
        end
        bus.acc_valid = 1'b0;
        bus.out_ready = 1'b0;

        // Backpressure with stray start/acc_valid; lane binding on batch 1
        start = 1'b1;
        step();
        start = 1'b0;
        do_beat("bp_b0", acc_a, lit_a,   mask_a, 5, 1'b0);
        do_beat("bp_b1", acc_b, lit_3k2, '1,     5, 1'b1);

        // Reset in ACC, then a fresh full pass from batch 0
        start = 1'b1;
        step();
        start = 1'b0;
        wait_acc_ready("rst_mid");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state("rst_mid");
        rom_mem[0] = '0;
        step();
        chk("rst_idle_busy", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pass_rom_aa", bus.rom_aa, 0);
        do_beat("lane_b0", acc_b, lit_k,   '1, 0, 1'b0);
        do_beat("lane_b1", acc_b, lit_3k2, '1, 0, 1'b1);
        step();
        chk("pass_done_pulse", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/fc3_bias_fetch_add.md
Name: fc3_bias_fetch_add

Overview:
Read-side sequencer for the FC3 bias ROM. It walks all output batches, issues a one-cycle active-low read per batch and captures the returned lane-packed biases. It adds those biases to the matching FC3 accumulator beat, then rounds, shifts and saturates each lane. It sits between the FC3 MAC array output and the final-score writeback, with valid/ready on both sides.

Parameters:
LANES, 16, output neurons per batch (matches ROM row width)
NUM_BATCH, 2, output batches per inference
AW, 1, ROM address width
BIAS_W, 34, signed bias width per lane
ACC_W, 34, signed accumulator width per lane
OUT_W, 8, signed output width per lane
SHIFT, 16, requantization right-shift (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins an inference pass
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last batch is accepted downstream
rom_aa  out  AW  ROM row address (batch index)
rom_cena  out  1  ROM read enable, active low
rom_qa  in  LANES*BIAS_W  ROM data; valid the cycle after rom_cena=0 is sampled
acc_valid  in  1  accumulator beat valid
acc_ready  out  1  block accepts accumulator beat
acc_data  in  LANES*ACC_W  lane-packed signed partial sums, lane 0 in LSBs
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  LANES*OUT_W  lane-packed signed requantized outputs

Behaviour:
- Reset values: busy=0, done=0, rom_cena=1, rom_aa=0, acc_ready=0, out_valid=0, out_data=0. Reset clears the FSM to IDLE, batch=0, bias_reg=0. Reset has priority over every other input, including mid-pass.
- FSM states: IDLE, FETCH, WAIT, ACC, OUT.
- IDLE: start=1 moves to FETCH with batch=0 and busy=1. Start in any other state is ignored.
- FETCH (1 cycle): rom_cena=0, rom_aa=batch. Moves to WAIT.
- WAIT (1 cycle): rom_cena=1; bias_reg<=rom_qa. Moves to ACC.
- ACC: acc_ready=1. On acc_valid&&acc_ready, out_data<=requant(acc_data,bias_reg) and out_valid<=1, then move to OUT. acc_ready=0 in every other state; acc_valid there is ignored.
- OUT: out_valid held and out_data stable until out_ready.
  - On out_ready with batch<NUM_BATCH-1: batch++ and move to FETCH.
  - On out_ready with batch==NUM_BATCH-1: done=1 for one cycle, busy=0, move to IDLE.
- rom_cena is high in every state except FETCH.
- Latency: start sampled at cycle 0 -> rom_cena low in cycle 1 -> bias captured end of cycle 2 -> acc_ready high from cycle 3 -> out_valid in the cycle after the accumulator handshake.
- Per-lane requant:
  - s = sext(acc)+sext(bias), width max(ACC_W,BIAS_W)+1, no overflow.
  - If SHIFT>0: s += 1<<(SHIFT-1) (round half up); r = s>>>SHIFT (arithmetic).
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- NUM_BATCH=1: OUT returns directly to IDLE with done.
- start and out_ready may both be high in OUT; start is ignored.

Decomposition:
- Package fc3_bias_pkg: FSM state enum, default LANES/NUM_BATCH/widths/SHIFT constants, and sat/round limit constants.
- Sub-module fc3_requant_lane: purely combinational per-lane add, round, shift and saturate. Instantiated LANES times; the sequencer registers the result.

Test Plan:
- Reset mid-pass: assert rst while in ACC -> next cycle all outputs at reset values and rom_cena=1. A following start runs a full pass from batch 0.
- Handshake timing: start at cycle 0, acc_valid held high -> rom_cena=0 with rom_aa=0 only in cycle 1, acc_ready first high in cycle 3, out_valid in cycle 4. With out_ready=1: rom_aa=1 FETCH in cycle 5, done pulse in cycle 9, busy low in cycle 9.
- Saturation: acc lane0=0, bias 750085376 -> out 127; acc lane1=0, bias -103524808 -> out -128.
- Rounding: acc=196608, bias=32768 -> 3.5 -> out 4; acc=-229376, bias=0 -> -3.5 -> out -3; acc=65535, bias=0 -> out 1.
- Backpressure: out_ready low for 5 cycles in OUT -> out_data stable, acc_ready=0, rom_cena=1, no ROM read issued. A stray start or acc_valid pulse during stall -> no effect.
- Per-lane binding: ROM row 1 holds distinct per-lane biases -> batch-1 output lane k uses bias row1[k] only. Lane-order check with acc=k<<16, bias=0, SHIFT=16 -> out lane k = k.
